// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues one imem
// word fetch at a time, hands the word to decode over valid/ready and
// applies trap/jump/branch redirects, draining any wrong-path response.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_valid_i,
  input  logic [31:0] jmp_target_i,
  input  logic        trap_i,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;     // address of the granted, in-flight fetch
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        mis_q, mis_d;

  logic        redir;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic [31:0] new_pc;

  // Redirect target selection: trap > jump > branch; misaligned br/jmp
  // targets fall back to the trap vector.
  always_comb begin
    redir   = (state_q != S_IDLE) && (trap_i || jmp_valid_i || br_taken_i);
    tgt     = trap_i ? TRAP_VEC : (jmp_valid_i ? jmp_target_i : br_target_i);
    tgt_mis = !trap_i && (tgt[1:0] != 2'b00);
    new_pc  = tgt_mis ? TRAP_VEC : tgt;
  end

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redir) begin
          // A granted request still returns a response that must be dropped.
          state_d = imem_gnt_i ? S_DRAIN : S_REQ;
        end else if (imem_gnt_i) begin
          addr_d  = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (redir || instr_ready_i) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redir) begin
      pc_d    = new_pc;
      valid_d = 1'b0;
      mis_d   = tgt_mis;
    end
  end

  // The request line is registered: it is high exactly while in REQ.
  assign req_d = (state_d == S_REQ);

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 32'd0;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign misalign_o    = mis_q;

endmodule
